// File: rtl/edge_detector_pkg.sv
// Shared types and constants for the edge detector slice.
// Debounce filter is built only when EDGE_DEBOUNCE_EN is defined.
package edge_detector_pkg;

    typedef enum logic [1:0] {
        S_LOW  = 2'b00,
        S_RISE = 2'b01,
        S_HIGH = 2'b10,
        S_FALL = 2'b11
    } state_e;

    // 10 ms of stability at 50 MHz
    localparam int unsigned DEBOUNCE_50MHZ = 500_000;

endpackage

// File: rtl/edge_detector_sync_debounce.sv
// Synchronizer for one asynchronous level, plus optional stability filter.
// Filter is built only when EDGE_DEBOUNCE_EN is defined.
module edge_detector_sync_debounce
    import edge_detector_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_50MHZ
) (
    input  logic clk_50MHz,
    input  logic reset,
    input  logic sig_in,
    output logic level
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_sync;

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
        end
    end

    assign s_sync = sync_q[SYNC_STAGES-1];

`ifdef EDGE_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          level_q;
    logic          level_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Level follows s_sync only after DEBOUNCE_CYCLES consecutive mismatches
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (s_sync != level_q) begin
            if (cnt_q == LAST) begin
                level_d = s_sync;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
`else
    // Undebounced: the last synchronizer flop is the level register
    if (DEBOUNCE_CYCLES == 0) begin : g_no_filter
    end

    assign level = s_sync;
`endif

endmodule

// File: rtl/edge_detector.sv
// Synchronized level edge detector: Moore FSM pulses and rising-edge count.
// Define EDGE_DEBOUNCE_EN to insert the debounce filter before the FSM.
module edge_detector
    import edge_detector_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_50MHZ,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk_50MHz,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             count_clr,
    output logic             level,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] edge_count
);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             lvl;

    edge_detector_sync_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sync (
        .clk_50MHz(clk_50MHz),
        .reset    (reset),
        .sig_in   (sig_in),
        .level    (lvl)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_LOW:  state_d = lvl ? S_RISE : S_LOW;
            S_RISE: state_d = lvl ? S_HIGH : S_FALL;
            S_HIGH: state_d = lvl ? S_HIGH : S_FALL;
            S_FALL: state_d = lvl ? S_RISE : S_LOW;
            default: state_d = S_LOW;
        endcase
    end

    assign rise_pulse = (state_q == S_RISE);
    assign fall_pulse = (state_q == S_FALL);

    // A clear coinciding with a rise keeps that rise
    always_comb begin
        cnt_d = cnt_q;
        if (count_clr) begin
            cnt_d = CNT_W'(rise_pulse);
        end else if (rise_pulse) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level      = lvl;
    assign edge_count = cnt_q;

endmodule

// File: tb/tb_edge_detector.sv
// Bench for edge_detector: vector tables, directed corners, random vs model.
// Honours EDGE_DEBOUNCE_EN the same way the design does.
module tb_edge_detector;
    import edge_detector_pkg::*;

    localparam int D  = 4;
    localparam int CW = 4;
`ifdef EDGE_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sig = 1'b0;
    logic          clr = 1'b0;
    logic          lvl;
    logic          rp;
    logic          fp;
    logic [CW-1:0] cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    edge_detector #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (CW)
    ) dut (
        .clk_50MHz (clk),
        .reset     (rst),
        .sig_in    (sig),
        .count_clr (clr),
        .level     (lvl),
        .rise_pulse(rp),
        .fall_pulse(fp),
        .edge_count(cnt)
    );

    // Reference: level history, sync output history, counter
    bit in_prev;
    bit s_hist[$];
    bit lh[3];
    int mcnt;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        in_prev = 1'b0;
        s_hist = {};
        for (int k = 0; k < D; k++) s_hist.push_back(1'b0);
        lh[0] = 1'b0;
        lh[1] = 1'b0;
        lh[2] = 1'b0;
        mcnt = 0;
    endfunction

    function automatic void model_edge(input bit in, input bit c);
        bit rise_prev;
        bit s_new;
        bit new_l;
        bit all_diff;
        rise_prev = lh[1] & ~lh[2];
        if (c) mcnt = int'(rise_prev);
        else mcnt = (mcnt + int'(rise_prev)) % (1 << CW);
        s_new = in_prev;
        in_prev = in;
        if (DEB) begin
            all_diff = 1'b1;
            for (int k = 0; k < D; k++)
                if (s_hist[s_hist.size()-1-k] == lh[0]) all_diff = 1'b0;
            new_l = all_diff ? s_hist[s_hist.size()-1] : lh[0];
        end else begin
            new_l = s_new;
        end
        s_hist.push_back(s_new);
        while (s_hist.size() > D) void'(s_hist.pop_front());
        lh[2] = lh[1];
        lh[1] = lh[0];
        lh[0] = new_l;
    endfunction

    function automatic bit m_rise();
        return lh[1] & ~lh[2];
    endfunction

    function automatic bit m_fall();
        return ~lh[1] & lh[2];
    endfunction

    task automatic step(input bit in, input bit c);
        sig = in;
        clr = c;
        @(posedge clk);
        model_edge(in, c);
        @(negedge clk);
        chk("level", int'(lvl), int'(lh[0]));
        chk("rise", int'(rp), int'(m_rise()));
        chk("fall", int'(fp), int'(m_fall()));
        chk("count", int'(cnt), mcnt);
        chk("excl", int'(rp & fp), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sig = 1'b0;
        clr = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_level", int'(lvl), 0);
        chk("rst_rise", int'(rp), 0);
        chk("rst_fall", int'(fp), 0);
        chk("rst_count", int'(cnt), 0);
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit in;
        bit c;
        bit r;
        bit f;
        bit l;
        int n;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(
        input bit in, input bit c, input bit r,
        input bit f, input bit l, input int n
    );
        vec_t v;
        v.in = in; v.c = c; v.r = r;
        v.f = f; v.l = l; v.n = n;
        tbl.push_back(v);
    endfunction

    initial begin
        bit found;
        int run;
        bit val;

        // Single rise then fall, cycle by cycle
        if (!DEB) begin
            add(1, 0, 0, 0, 0, 0);
            add(1, 0, 0, 0, 1, 0);
            add(1, 0, 1, 0, 1, 0);
            add(1, 0, 0, 0, 1, 1);
            add(0, 0, 0, 0, 1, 1);
            add(0, 0, 0, 0, 0, 1);
            add(0, 0, 0, 1, 0, 1);
            add(0, 0, 0, 0, 0, 1);
        end else begin
            for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 0, 0);
            add(1, 0, 0, 0, 1, 0);
            add(1, 0, 1, 0, 1, 0);
            for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 1, 1);
            for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 1, 1);
            add(0, 0, 0, 0, 0, 1);
            add(0, 0, 0, 1, 0, 1);
            for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 1);
        end

        // 1: reset then quiet input
        model_reset();
        do_reset();
        for (int i = 0; i < 20; i++) step(0, 0);
        chk("quiet_count", int'(cnt), 0);

        // 2/3: vector table
        do_reset();
        foreach (tbl[i]) begin
            step(tbl[i].in, tbl[i].c);
            chk("tbl_rise", int'(rp), int'(tbl[i].r));
            chk("tbl_fall", int'(fp), int'(tbl[i].f));
            chk("tbl_level", int'(lvl), int'(tbl[i].l));
            chk("tbl_count", int'(cnt), tbl[i].n);
        end

        // 3: short glitch must not pass the filter
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0);
        for (int i = 0; i < 12; i++) step(0, 0);
        if (DEB) chk("glitch_count", int'(cnt), 0);

        // 4: sixteen rises wrap the counter
        do_reset();
        for (int e = 0; e < 16; e++) begin
            for (int i = 0; i < 6; i++) step(1, 0);
            for (int i = 0; i < 6; i++) step(0, 0);
        end
        for (int i = 0; i < 6; i++) step(0, 0);
        chk("wrap_count", int'(cnt), 0);

        // 4: clear coincident with a rise keeps that rise
        for (int i = 0; i < 3; i++) step(0, 0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1, 0);
            found = rp;
        end
        chk("clr_rise_seen", int'(found), 1);
        step(1, 1);
        chk("clr_with_rise", int'(cnt), 1);
        step(1, 1);
        chk("clr_alone", int'(cnt), 0);

        // 5: toggle every cycle
        do_reset();
        for (int i = 0; i < 40; i++) step(i[0], 0);
        for (int i = 0; i < 12; i++) step(0, 0);

        // 6: reset while rise_pulse is high
        do_reset();
        for (int e = 0; e < 2; e++) begin
            for (int i = 0; i < 6; i++) step(1, 0);
            for (int i = 0; i < 6; i++) step(0, 0);
        end
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1, 0);
            found = rp;
        end
        chk("mid_rise_seen", int'(found), 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rise", int'(rp), 0);
        chk("async_count", int'(cnt), 0);
        chk("async_level", int'(lvl), 0);
        chk("async_state", int'(dut.state_q == S_LOW), 1);
        do_reset();

        // Random runs with occasional clears and resets
        for (int r = 0; r < 120; r++) begin
            val = 1'(($urandom() >> 3) & 1);
            run = int'($urandom_range(1, 8));
            for (int i = 0; i < run; i++)
                step(val, $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 40) == 0) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
